// File: rtl/fp_mult_seq_ctrl_pkg.sv
// Shared types and constants for the sequential floating-point multiply controller.
// Holds the FSM state enum, operand classes, flag bit positions and the canonical qNaN.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 24;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    localparam int BIAS    = exp_bias(FP_EXP_W);
    localparam int EXP_MAX = (1 << FP_EXP_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP,
        S_MULT,
        S_NORM,
        S_RND,
        S_DONE
    } state_t;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } op_class_t;

    // A zero exponent is treated as zero whatever the fraction (denormals are flushed).
    function automatic op_class_t classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_nz);
        if (exp_zero) return ZERO;
        if (exp_ones) return frac_nz ? NAN : INF;
        return NORM;
    endfunction

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_mult_seq_ctrl_if.sv
// Operand-issue and result handshakes of the floating-point multiply controller.
// The controller takes the slave view; the issuer/writeback side takes the master view.
interface fp_mult_seq_ctrl_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_flags;

    modport master(
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave(
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_mult_seq_ctrl_mant.sv
// Iterative unsigned MANT_W x MANT_W shift-add multiplier, one multiplier bit per cycle.
// done is high during the final iteration; product is valid the cycle after.
module mant_shift_add #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MANT_W-1:0]     a,
    input  logic [MANT_W-1:0]     b,
    output logic                  done,
    output logic [2*MANT_W-1:0]   product
);
    localparam int CW = $clog2(MANT_W);
    localparam logic [CW-1:0] LAST = CW'(MANT_W - 1);

    logic                busy;
    logic [CW-1:0]       cnt;
    logic [2*MANT_W-1:0] mcand;
    logic [MANT_W-1:0]   mplier;
    logic [2*MANT_W-1:0] acc;

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{MANT_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == LAST) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign done    = busy && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/fp_mult_seq_ctrl.sv
// Sequencing controller for the real multiplier: classify, exponent sum, iterative
// mantissa multiply, normalize, round-to-nearest-even, and pack with exception flags.
module fp_mult_seq_ctrl
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input logic               clk,
    input logic               rst_n,
    fp_mult_seq_ctrl_if.slave bus
);
    localparam int W      = EXP_W + MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int EW     = EXP_W + 2;
    localparam logic [EW-1:0] BIAS_X = EW'(exp_bias(EXP_W));
    localparam logic [EW-1:0] EMAX_X = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    state_t state_q, state_d;

    logic [W-1:0]      a_q, b_q, res_q;
    logic [3:0]        flags_q;
    logic              sign_q, guard_q, sticky_q;
    logic [EW-1:0]     e_q;
    logic [FRAC_W-1:0] frac_q;

    logic [EXP_W-1:0]    ea, eb;
    logic [FRAC_W-1:0]   fa, fb;
    op_class_t           cls_a, cls_b;
    logic                sign_w, spec_hit, mult_start, mult_done;
    logic [EW-1:0]       e_sum, rnd_exp;
    logic [W-1:0]        spec_data, rnd_data;
    logic [3:0]          spec_flags, rnd_flags;
    logic [2*MANT_W-1:0] prod;
    logic                rnd_inc;
    logic [FRAC_W:0]     frac_sum;

    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign fa     = a_q[FRAC_W-1:0];
    assign fb     = b_q[FRAC_W-1:0];
    assign cls_a  = classify(ea == '0, &ea, |fa);
    assign cls_b  = classify(eb == '0, &eb, |fb);
    assign sign_w = a_q[W-1] ^ b_q[W-1];
    // Two guard bits keep the signed sum free of wrap for any pair of exponents.
    assign e_sum  = {2'b00, ea} + {2'b00, eb} - BIAS_X;

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        spec_hit   = 1'b1;
        spec_flags = '0;
        spec_data  = {sign_w, {(W-1){1'b0}}};
        if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO) ||
            (cls_a == ZERO && cls_b == INF)) begin
            spec_data           = QNAN_W;
            spec_flags[FLG_INV] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            spec_data = {sign_w, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (cls_a != ZERO && cls_b != ZERO) begin
            spec_hit = 1'b0;
        end
    end

    assign mult_start = (state_q == S_EXP) && !spec_hit;

    mant_shift_add #(.MANT_W(MANT_W)) u_mant (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mult_start),
        .a      ({1'b1, fa}),
        .b      ({1'b1, fb}),
        .done   (mult_done),
        .product(prod)
    );

    // The hidden bit is always 1, so a fraction carry-out is exactly the mantissa overflow.
    assign rnd_inc  = guard_q & (sticky_q | frac_q[0]);
    assign frac_sum = {1'b0, frac_q} + (FRAC_W+1)'(rnd_inc);
    assign rnd_exp  = e_q + EW'(frac_sum[FRAC_W]);

    always_comb begin
        rnd_flags          = '0;
        rnd_flags[FLG_INX] = guard_q | sticky_q;
        rnd_data           = {sign_q, rnd_exp[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        if ($signed(rnd_exp) >= $signed(EMAX_X)) begin
            rnd_data           = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            rnd_flags[FLG_OVF] = 1'b1;
            rnd_flags[FLG_INX] = 1'b1;
        end else if (rnd_exp[EW-1] || rnd_exp == '0) begin
            rnd_data           = {sign_q, {(W-1){1'b0}}};
            rnd_flags[FLG_UNF] = 1'b1;
            rnd_flags[FLG_INX] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_EXP;
            S_EXP:  state_d = spec_hit ? S_DONE : S_MULT;
            S_MULT: if (mult_done) state_d = S_NORM;
            S_NORM: state_d = S_RND;
            S_RND:  state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            e_q      <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    a_q <= bus.in_a;
                    b_q <= bus.in_b;
                end
                S_EXP: begin
                    sign_q <= sign_w;
                    e_q    <= e_sum;
                    if (spec_hit) begin
                        res_q   <= spec_data;
                        flags_q <= spec_flags;
                    end
                end
                // A product in [2,4) is taken one bit higher; the exponent bumps to match.
                S_NORM: begin
                    e_q <= e_q + EW'(prod[2*MANT_W-1]);
                    if (prod[2*MANT_W-1]) begin
                        frac_q   <= prod[2*MANT_W-2 -: FRAC_W];
                        guard_q  <= prod[MANT_W-1];
                        sticky_q <= |prod[MANT_W-2:0];
                    end else begin
                        frac_q   <= prod[2*MANT_W-3 -: FRAC_W];
                        guard_q  <= prod[MANT_W-2];
                        sticky_q <= |prod[MANT_W-3:0];
                    end
                end
                S_RND: begin
                    res_q   <= rnd_data;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = res_q;
    assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Self-checking bench for fp_mult_seq_ctrl: directed vector table, handshake corner
// sequences, and random operands against an arithmetic reference model.
module tb_fp_mult_seq_ctrl;
    import fp_pkg::*;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;
    localparam int W      = EXP_W + MANT_W;
    localparam int LAT_N  = MANT_W + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp_mult_seq_ctrl_if #(.W(W)) bus ();

    fp_mult_seq_ctrl #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
    task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] d, output logic [3:0] f, output int lat);
        int ea, eb, e, k;
        logic s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == EXP_MAX) && (a[22:0] == 0);
        ib = (eb == EXP_MAX) && (b[22:0] == 0);
        na = (ea == EXP_MAX) && (a[22:0] != 0);
        nb = (eb == EXP_MAX) && (b[22:0] != 0);
        lat = 1;
        f   = 4'b0000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            d = QNAN;
            f = 4'b1000;
        end else if (ia || ib) begin
            d = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            d = {s, 31'h0};
        end else begin
            lat  = LAT_N;
            ma   = 64'(a[22:0]) + (64'd1 << 23);
            mb   = 64'(b[22:0]) + (64'd1 << 23);
            p    = ma * mb;
            k    = (p >= (64'd1 << 47)) ? 24 : 23;
            q    = p >> k;
            rem  = p - (q << k);
            half = 64'd1 << (k - 1);
            e    = ea + eb - BIAS + (k - 23);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e = e + 1;
            end
            if (e >= EXP_MAX) begin
                d = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                d = {s, 31'h0};
                f = 4'b0011;
            end else begin
                d = {s, e[7:0], q[22:0]};
                f = {3'b000, rem != 0};
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts rising edges after acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) return;
        end
        lat = -1;
    endtask

    task automatic consume(output logic [31:0] d, output logic [3:0] f);
        d = bus.out_data;
        f = bus.out_flags;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic [3:0] ef, input int elat);
        int          lat;
        logic [31:0] d;
        logic [3:0]  f;
        issue(a, b);
        wait_valid(lat);
        check({name, " latency"}, 64'(lat), 64'(elat));
        consume(d, f);
        check({name, " data"}, 64'(d), 64'(ed));
        check({name, " flags"}, 64'(f), 64'(ef));
    endtask

    function automatic logic [31:0] gen_op();
        int          m;
        logic [31:0] v;
        m = $urandom_range(0, 3);
        v = $urandom;
        if (m == 1 || m == 2) begin
            v[30:23] = 8'($urandom_range(100, 154));
        end else if (m == 3) begin
            case ($urandom_range(0, 4))
                0: v[30:23] = 8'h00;
                1: v[30:23] = 8'hFF;
                2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
                3: v[30:23] = 8'($urandom_range(1, 20));
                default: v[30:23] = 8'($urandom_range(235, 254));
            endcase
        end
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d;
        logic [3:0]  f0, f, ef;
        logic [31:0] ed, ra, rb;
        int          lat, elat;
        bit          seen;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_N};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, LAT_N};
        vecs[2]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, LAT_N};
        vecs[3]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, LAT_N};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1};
        vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1};
        vecs[6]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1};
        vecs[7]  = '{32'hC0400000, 32'h40800000, 32'hC1400000, 4'b0000, LAT_N};
        vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1};
        vecs[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 1};
        vecs[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, LAT_N};
        vecs[11] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000, 1};
        vecs[12] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, LAT_N};
        vecs[13] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, LAT_N};

        #2 rst_n = 1'b0;
        #3;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_data", 64'(bus.out_data), 64'd0);
        check("reset out_flags", 64'(bus.out_flags), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].f, vecs[i].lat);
        end

        // Backpressure: result held, a second request ignored, one bubble before acceptance.
        issue(32'h3FC00000, 32'h40000000);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'(LAT_N));
        d0 = bus.out_data;
        f0 = bus.out_flags;
        check("bp first data", 64'(d0), 64'h40400000);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hC0400000;
        bus.in_b     = 32'h40800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp hold valid", 64'(bus.out_valid), 64'd1);
            check("bp hold data", 64'(bus.out_data), 64'(d0));
            check("bp hold flags", 64'(bus.out_flags), 64'(f0));
            check("bp in_ready low", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp bubble valid", 64'(bus.out_valid), 64'd0);
        check("bp bubble in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp second latency", 64'(lat), 64'(LAT_N));
        consume(d, f);
        check("bp second data", 64'(d), 64'hC1400000);
        check("bp second flags", 64'(f), 64'd0);

        // Asynchronous reset during the mantissa loop discards the operation.
        issue(32'h3FC00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort in_ready", 64'(bus.in_ready), 64'd1);
        check("abort out_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort no result", 64'(seen), 64'd0);
        check("abort idle in_ready", 64'(bus.in_ready), 64'd1);
        run_op("after abort", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_N);

        for (int i = 0; i < 300; i++) begin
            ra = gen_op();
            rb = gen_op();
            ref_mult(ra, rb, ed, ef, elat);
            run_op($sformatf("rand%0d a=%08h b=%08h", i, ra, rb), ra, rb, ed, ef, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
